river_cross: RTL and testbench



---
 rtl/river_cross.sv | 187 ++++++++++++++++++
 tb/tb_river_cross.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/river_cross.sv
// Generalised river-crossing puzzle engine: legality checking, move counting and solved detection.
// Optional embedded formal properties are compiled in when RIVER_FV_EN is defined.
module river_cross #(
    parameter int                             N_ITEMS  = 3,
    parameter int                             BOAT_CAP = 1,
    parameter logic [N_ITEMS*N_ITEMS-1:0]     CONFLICT = 9'b000_100_010,
    parameter int                             CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_valid,
    input  logic [N_ITEMS-1:0]   move_sel,
    output logic                 move_ready,
    output logic                 move_accept,
    output logic                 move_reject,
    output logic [1:0]           err_code,
    output logic [N_ITEMS:0]     state,
    output logic                 solved,
    output logic [CNT_W-1:0]     moves
);

    localparam int                PC_W  = $clog2(N_ITEMS + 1);
    localparam logic [PC_W-1:0]   CAP_V = PC_W'(BOAT_CAP);

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CAP    = 2'd1;
    localparam logic [1:0] ERR_BANK   = 2'd2;
    localparam logic [1:0] ERR_UNSAFE = 2'd3;

    typedef enum logic {S_PLAY = 1'b0, S_SOLVED = 1'b1} fsm_t;

    fsm_t                r_fsm;
    fsm_t                w_fsm_next;
    logic [N_ITEMS-1:0]  r_items;
    logic                r_ferry;
    logic [CNT_W-1:0]    r_moves;
    logic [1:0]          r_err;
    logic                r_accept;
    logic                r_reject;

    logic                w_eval;
    logic [PC_W-1:0]     w_popcnt;
    logic                w_err_cap;
    logic                w_err_bank;
    logic                w_err_unsafe;
    logic                w_legal;
    logic [1:0]          w_err_cause;
    logic [N_ITEMS-1:0]  w_items_nx;
    logic                w_ferry_nx;
    logic [N_ITEMS-1:0]  w_off_nx;
    logic [N_ITEMS-1:0]  w_unsafe_row;
    logic                w_solving;
    logic [N_ITEMS-1:0]  w_conf [N_ITEMS];

    // Symmetrise the conflict matrix; an item never conflicts with itself.
    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_conf_row
        for (genvar gj = 0; gj < N_ITEMS; gj++) begin : g_conf_col
            if (gi == gj) begin : g_diag
                assign w_conf[gi][gj] = 1'b0;
            end else begin : g_pair
                assign w_conf[gi][gj] = CONFLICT[gi*N_ITEMS+gj] | CONFLICT[gj*N_ITEMS+gi];
            end
        end
    end

    assign w_eval     = move_valid && move_ready;
    assign w_items_nx = r_items ^ move_sel;
    assign w_ferry_nx = ~r_ferry;
    // Items left on the bank the ferryman is leaving are unattended.
    assign w_off_nx   = w_items_nx ^ {N_ITEMS{w_ferry_nx}};

    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_unsafe
        assign w_unsafe_row[gi] = w_off_nx[gi] & (|(w_conf[gi] & w_off_nx));
    end

    always_comb begin
        w_popcnt = '0;
        for (int k = 0; k < N_ITEMS; k++) begin
            w_popcnt = w_popcnt + PC_W'(move_sel[k]);
        end
    end

    assign w_err_cap    = (w_popcnt > CAP_V);
    assign w_err_bank   = |(move_sel & (r_items ^ {N_ITEMS{r_ferry}}));
    assign w_err_unsafe = |w_unsafe_row;
    assign w_legal      = !w_err_cap && !w_err_bank && !w_err_unsafe;
    assign w_solving    = w_eval && w_legal && (&{w_ferry_nx, w_items_nx});

    always_comb begin
        w_err_cause = ERR_NONE;
        if (w_err_cap) begin
            w_err_cause = ERR_CAP;
        end else if (w_err_bank) begin
            w_err_cause = ERR_BANK;
        end else if (w_err_unsafe) begin
            w_err_cause = ERR_UNSAFE;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_PLAY;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_PLAY:   if (w_solving) w_fsm_next = S_SOLVED;
            S_SOLVED: w_fsm_next = S_SOLVED;
            default:  w_fsm_next = S_PLAY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        move_ready = 1'b0;
        solved     = 1'b0;
        case (r_fsm)
            S_PLAY:   move_ready = 1'b1;
            S_SOLVED: solved     = 1'b1;
            default:  move_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_items  <= '0;
            r_ferry  <= 1'b0;
            r_moves  <= '0;
            r_err    <= ERR_NONE;
            r_accept <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_accept <= 1'b0;
            r_reject <= 1'b0;
            if (w_eval) begin
                if (w_legal) begin
                    r_items  <= w_items_nx;
                    r_ferry  <= w_ferry_nx;
                    r_err    <= ERR_NONE;
                    r_accept <= 1'b1;
                    if (r_moves != {CNT_W{1'b1}}) begin
                        r_moves <= r_moves + 1'b1;
                    end
                end else begin
                    r_err    <= w_err_cause;
                    r_reject <= 1'b1;
                end
            end
        end
    end

    assign move_accept = r_accept;
    assign move_reject = r_reject;
    assign err_code    = r_err;
    assign state       = {r_ferry, r_items};
    assign moves       = r_moves;

`ifdef RIVER_FV_EN
    logic [N_ITEMS-1:0] w_off_cur;
    logic [N_ITEMS-1:0] w_cur_unsafe_row;

    assign w_off_cur = r_items ^ {N_ITEMS{r_ferry}};
    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_fv_unsafe
        assign w_cur_unsafe_row[gi] = w_off_cur[gi] & (|(w_conf[gi] & w_off_cur));
    end

    default clocking fv_cb @(posedge clk); endclocking
    default disable iff (rst);

    a_never_unsafe: assert property (!(|w_cur_unsafe_row));
    a_pulse_excl:   assert property (!(move_accept && move_reject));
    a_moves_mono:   assert property (!$past(rst) |-> (r_moves >= $past(r_moves)));
    a_solved_stick: assert property ((r_fsm == S_SOLVED) |=> (r_fsm == S_SOLVED));

    c_solved:     cover property (solved);
    c_err_cap:    cover property (move_reject && err_code == ERR_CAP);
    c_err_bank:   cover property (move_reject && err_code == ERR_BANK);
    c_err_unsafe: cover property (move_reject && err_code == ERR_UNSAFE);
`endif

endmodule

// File: tb/tb_river_cross.sv
// Randomised and directed bench for river_cross: two instances (cap 1 / 8-bit count, cap 2 / 3-bit count)
// share one stimulus stream and are compared every cycle against a per-instance puzzle model.
module tb_river_cross;

    localparam logic [8:0] CONF = 9'b000_100_010;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_valid;
    logic [2:0] move_sel;

    logic       d0_ready, d0_acc, d0_rej, d0_solved;
    logic [1:0] d0_err;
    logic [3:0] d0_state;
    logic [7:0] d0_moves;

    logic       d1_ready, d1_acc, d1_rej, d1_solved;
    logic [1:0] d1_err;
    logic [3:0] d1_state;
    logic [2:0] d1_moves;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    river_cross #(.N_ITEMS(3), .BOAT_CAP(1), .CONFLICT(CONF), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst), .move_valid(move_valid), .move_sel(move_sel),
        .move_ready(d0_ready), .move_accept(d0_acc), .move_reject(d0_rej),
        .err_code(d0_err), .state(d0_state), .solved(d0_solved), .moves(d0_moves)
    );

    river_cross #(.N_ITEMS(3), .BOAT_CAP(2), .CONFLICT(CONF), .CNT_W(3)) u_d1 (
        .clk(clk), .rst(rst), .move_valid(move_valid), .move_sel(move_sel),
        .move_ready(d1_ready), .move_accept(d1_acc), .move_reject(d1_rej),
        .err_code(d1_err), .state(d1_state), .solved(d1_solved), .moves(d1_moves)
    );

    // Puzzle model: bank per item and ferryman, 0 = near, 1 = far.
    int m_bank  [2][3];
    int m_ferry [2];
    int m_moves [2];
    int m_err   [2];
    int m_acc   [2];
    int m_rej   [2];
    int m_solved[2];
    int m_cap   [2] = '{1, 2};
    int m_max   [2] = '{255, 7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit conflicts(input int i, input int j);
        return (CONF[i*3+j] | CONF[j*3+i]) == 1'b1;
    endfunction

    task automatic model_reset(input int m);
        for (int i = 0; i < 3; i++) m_bank[m][i] = 0;
        m_ferry[m] = 0; m_moves[m] = 0; m_err[m] = 0;
        m_acc[m] = 0; m_rej[m] = 0; m_solved[m] = 0;
    endtask

    task automatic model_step(input int m, input bit r, input bit v, input logic [2:0] sel);
        int cnt, e, nf, far_all;
        int nb[3];
        if (r) begin
            model_reset(m);
            return;
        end
        m_acc[m] = 0;
        m_rej[m] = 0;
        if (!v || m_solved[m] != 0) return;
        cnt = 0;
        e   = 0;
        for (int i = 0; i < 3; i++) if (sel[i]) cnt++;
        if (cnt > m_cap[m]) e = 1;
        if (e == 0)
            for (int i = 0; i < 3; i++)
                if (sel[i] && m_bank[m][i] != m_ferry[m]) e = 2;
        nf = 1 - m_ferry[m];
        for (int i = 0; i < 3; i++) nb[i] = sel[i] ? 1 - m_bank[m][i] : m_bank[m][i];
        if (e == 0)
            for (int i = 0; i < 3; i++)
                for (int j = i + 1; j < 3; j++)
                    if (conflicts(i, j) && nb[i] != nf && nb[j] != nf) e = 3;
        if (e == 0) begin
            for (int i = 0; i < 3; i++) m_bank[m][i] = nb[i];
            m_ferry[m] = nf;
            if (m_moves[m] < m_max[m]) m_moves[m]++;
            m_acc[m] = 1;
            m_err[m] = 0;
            far_all = nf;
            for (int i = 0; i < 3; i++) if (nb[i] == 0) far_all = 0;
            if (far_all != 0) m_solved[m] = 1;
        end else begin
            m_rej[m] = 1;
            m_err[m] = e;
        end
    endtask

    function automatic logic [3:0] model_state(input int m);
        return {1'(m_ferry[m]), 1'(m_bank[m][2]), 1'(m_bank[m][1]), 1'(m_bank[m][0])};
    endfunction

    task automatic check_dut(input int m, input logic [3:0] st, input logic [7:0] mv,
                             input logic [1:0] er, input logic a, input logic rj,
                             input logic sv, input logic rd);
        string p;
        p = (m == 0) ? "d0" : "d1";
        chk({p, ".state"},  32'(st), 32'(model_state(m)));
        chk({p, ".moves"},  32'(mv), 32'(m_moves[m]));
        chk({p, ".err"},    32'(er), 32'(m_err[m]));
        chk({p, ".accept"}, 32'(a),  32'(m_acc[m]));
        chk({p, ".reject"}, 32'(rj), 32'(m_rej[m]));
        chk({p, ".solved"}, 32'(sv), 32'(m_solved[m]));
        chk({p, ".ready"},  32'(rd), 32'(m_solved[m] == 0));
    endtask

    // One transaction: drive, clock, update model, compare, print.
    task automatic cycle(input bit r, input bit v, input logic [2:0] sel);
        rst        = r;
        move_valid = v;
        move_sel   = sel;
        @(posedge clk);
        #1;
        cyc++;
        model_step(0, r, v, sel);
        model_step(1, r, v, sel);
        check_dut(0, d0_state, d0_moves, d0_err, d0_acc, d0_rej, d0_solved, d0_ready);
        check_dut(1, d1_state, {5'd0, d1_moves}, d1_err, d1_acc, d1_rej, d1_solved, d1_ready);
        $display("cyc %0d rst=%0b v=%0b sel=%03b | d0 st=%04b mv=%0d err=%0d a=%0b r=%0b | d1 st=%04b mv=%0d err=%0d a=%0b r=%0b",
                 cyc, r, v, sel, d0_state, d0_moves, d0_err, d0_acc, d0_rej,
                 d1_state, d1_moves, d1_err, d1_acc, d1_rej);
    endtask

    task automatic classic();
        logic [2:0] seq [7];
        seq = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
        for (int k = 0; k < 7; k++) cycle(1'b0, 1'b1, seq[k]);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        rst = 1'b1; move_valid = 1'b0; move_sel = '0;
        cycle(1'b1, 1'b0, 3'b000);
        cycle(1'b1, 1'b0, 3'b000);
        chk("reset.ready", 32'(d0_ready), 32'd1);

        // Classic solution, then an ignored request while solved.
        classic();
        chk("classic.state", 32'(d0_state), 32'hF);
        chk("classic.moves", 32'(d0_moves), 32'd7);
        cycle(1'b0, 1'b1, 3'b010);
        chk("solved.hold", 32'(d0_state), 32'hF);

        // Wolf first: unsafe.
        cycle(1'b1, 1'b0, 3'b000);
        cycle(1'b0, 1'b1, 3'b100);
        chk("wolf.err", 32'(d0_err), 32'd3);

        // Two items: cap error with cap 1, accepted with cap 2 under this conflict set.
        cycle(1'b1, 1'b0, 3'b000);
        cycle(1'b0, 1'b1, 3'b011);
        chk("cap1.err", 32'(d0_err), 32'd1);
        chk("cap2.acc", 32'(d1_acc), 32'd1);

        // Item not with ferryman.
        cycle(1'b1, 1'b0, 3'b000);
        cycle(1'b0, 1'b1, 3'b010);
        cycle(1'b0, 1'b1, 3'b100);
        chk("bank.err", 32'(d0_err), 32'd2);
        chk("bank.state", 32'(d0_state), 32'hA);

        // Saturation on the 3-bit counter.
        cycle(1'b1, 1'b0, 3'b000);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 3'b010);
        chk("sat.moves", 32'(d1_moves), 32'd7);

        // Reset mid-play (also coinciding with a request), then classic again.
        cycle(1'b1, 1'b0, 3'b000);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, (k == 1) ? 3'b000 : 3'b010);
        cycle(1'b1, 1'b1, 3'b010);
        classic();

        // Random play with occasional reset.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
